// File: rtl/branch_resolve.sv
// Branch resolution: carries D-stage predictions through E/M, flags mispredicts, feeds predictor updates.
// Optional BRANCH_STAT_EN adds saturating branch/mispredict/nullify counters.
module branch_resolve #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned STAT_W = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            stallE,
   input  logic            flushE,
   input  logic            stallM,
   input  logic            flushM,
   input  logic            branchD,
   input  logic            branchL_D,
   input  logic            pred_takeD,
   input  logic [PC_W-1:0] pcD,
   input  logic [PC_W-1:0] targetD,
   input  logic            actual_takeE,
   output logic            mispredE,
   output logic [PC_W-1:0] redirect_pcE,
   output logic            flush_frontE,
   output logic            nullify_dsE,
   output logic            branchM,
   output logic            actual_takeM,
   output logic [PC_W-1:0] pcM,
   output logic            pred_takeM
`ifdef BRANCH_STAT_EN
   ,
   output logic [STAT_W-1:0] stat_branch,
   output logic [STAT_W-1:0] stat_mispred,
   output logic [STAT_W-1:0] stat_nullify
`endif
);

   logic            branch_e_q, branch_e_d;
   logic            branch_l_e_q, branch_l_e_d;
   logic            pred_take_e_q, pred_take_e_d;
   logic [PC_W-1:0] pc_e_q, pc_e_d;
   logic [PC_W-1:0] target_e_q, target_e_d;
   logic            done_e_q, done_e_d;

   logic            branch_m_q, branch_m_d;
   logic            actual_take_m_q, actual_take_m_d;
   logic [PC_W-1:0] pc_m_q, pc_m_d;
   logic            pred_take_m_q, pred_take_m_d;
   logic            issued_m_q, issued_m_d;

   // E-stage compare; done_e_q suppresses repeats while the branch is held in E
   always_comb begin
      mispredE     = branch_e_q & ~done_e_q & (pred_take_e_q != actual_takeE);
      nullify_dsE  = branch_e_q & branch_l_e_q & ~actual_takeE & ~done_e_q;
      flush_frontE = mispredE;
      redirect_pcE = '0;
      if (mispredE) begin
         redirect_pcE = actual_takeE ? target_e_q : (pc_e_q + PC_W'(8));
      end
   end

   always_comb begin
      branch_e_d    = branch_e_q;
      branch_l_e_d  = branch_l_e_q;
      pred_take_e_d = pred_take_e_q;
      pc_e_d        = pc_e_q;
      target_e_d    = target_e_q;
      done_e_d      = done_e_q;
      if (flushE) begin
         branch_e_d    = 1'b0;
         branch_l_e_d  = 1'b0;
         pred_take_e_d = 1'b0;
         pc_e_d        = '0;
         target_e_d    = '0;
         done_e_d      = 1'b0;
      end else if (stallE) begin
         done_e_d = done_e_q | mispredE | nullify_dsE;
      end else begin
         branch_e_d    = branchD;
         branch_l_e_d  = branchL_D;
         pred_take_e_d = pred_takeD;
         pc_e_d        = pcD;
         target_e_d    = targetD;
         done_e_d      = 1'b0;
      end
   end

   // issued_m_q marks a branch already reported while M is stalled
   always_comb begin
      branch_m_d      = branch_m_q;
      actual_take_m_d = actual_take_m_q;
      pc_m_d          = pc_m_q;
      pred_take_m_d   = pred_take_m_q;
      issued_m_d      = issued_m_q;
      if (flushM) begin
         branch_m_d      = 1'b0;
         actual_take_m_d = 1'b0;
         pc_m_d          = '0;
         pred_take_m_d   = 1'b0;
         issued_m_d      = 1'b0;
      end else if (stallM) begin
         issued_m_d = issued_m_q | branch_m_q;
      end else begin
         branch_m_d      = branch_e_q;
         actual_take_m_d = actual_takeE;
         pc_m_d          = pc_e_q;
         pred_take_m_d   = pred_take_e_q;
         issued_m_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         branch_e_q      <= 1'b0;
         branch_l_e_q    <= 1'b0;
         pred_take_e_q   <= 1'b0;
         pc_e_q          <= '0;
         target_e_q      <= '0;
         done_e_q        <= 1'b0;
         branch_m_q      <= 1'b0;
         actual_take_m_q <= 1'b0;
         pc_m_q          <= '0;
         pred_take_m_q   <= 1'b0;
         issued_m_q      <= 1'b0;
      end else begin
         branch_e_q      <= branch_e_d;
         branch_l_e_q    <= branch_l_e_d;
         pred_take_e_q   <= pred_take_e_d;
         pc_e_q          <= pc_e_d;
         target_e_q      <= target_e_d;
         done_e_q        <= done_e_d;
         branch_m_q      <= branch_m_d;
         actual_take_m_q <= actual_take_m_d;
         pc_m_q          <= pc_m_d;
         pred_take_m_q   <= pred_take_m_d;
         issued_m_q      <= issued_m_d;
      end
   end

   always_comb begin
      branchM      = branch_m_q & ~issued_m_q;
      actual_takeM = actual_take_m_q;
      pcM          = pc_m_q;
      pred_takeM   = pred_take_m_q;
   end

`ifdef BRANCH_STAT_EN
   logic [STAT_W-1:0] stat_branch_q, stat_branch_d;
   logic [STAT_W-1:0] stat_mispred_q, stat_mispred_d;
   logic [STAT_W-1:0] stat_nullify_q, stat_nullify_d;

   always_comb begin
      stat_branch_d  = stat_branch_q;
      stat_mispred_d = stat_mispred_q;
      stat_nullify_d = stat_nullify_q;
      if (branchM && (stat_branch_q != '1)) begin
         stat_branch_d = stat_branch_q + STAT_W'(1);
      end
      if (mispredE && (stat_mispred_q != '1)) begin
         stat_mispred_d = stat_mispred_q + STAT_W'(1);
      end
      if (nullify_dsE && (stat_nullify_q != '1)) begin
         stat_nullify_d = stat_nullify_q + STAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stat_branch_q  <= '0;
         stat_mispred_q <= '0;
         stat_nullify_q <= '0;
      end else begin
         stat_branch_q  <= stat_branch_d;
         stat_mispred_q <= stat_mispred_d;
         stat_nullify_q <= stat_nullify_d;
      end
   end

   always_comb begin
      stat_branch  = stat_branch_q;
      stat_mispred = stat_mispred_q;
      stat_nullify = stat_nullify_q;
   end
`endif

endmodule
